ac_motor_gate_driver: RTL

//   Downstream stage of the vector-control timer. Consumes the one-hot U_0/U_LOW/U_HIGH

---
 rtl/ac_motor_gate_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ac_motor_gate_driver.sv
// Six-switch inverter gate driver: maps the commanded SVM vector onto per-phase
// hi/lo gates with dead-time insertion, shoot-through protection and a sticky fault.
module ac_motor_gate_driver #(
  parameter int unsigned DEAD_CYCLES = 100,
  parameter int unsigned DT_W        = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic       U_0,
  input  logic       U_LOW,
  input  logic       U_HIGH,
  input  logic [2:0] SECTOR,
  output logic [2:0] GATE_HI,
  output logic [2:0] GATE_LO,
  output logic       FAULT
);

  localparam int unsigned NPH = 3;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_DEAD,
    PH_ON_HI,
    PH_ON_LO
  } ph_state_t;

  ph_state_t       r_state [NPH];
  logic [DT_W-1:0] r_cnt   [NPH];
  logic [2:0]      r_u_q;       // {U_HIGH, U_LOW, U_0}
  logic            r_en_q;
  logic [2:0]      r_sector_q;
  logic [2:0]      r_gate_hi;
  logic [2:0]      r_gate_lo;
  logic            r_fault;

  logic       w_u_onehot;
  logic       w_u_zero;
  logic       w_sec_load;
  logic       w_sec_valid;
  logic       w_fault_now;
  logic [2:0] w_sector_nxt;
  logic [2:0] w_target;

  // Switching state per sector, bit order C B A, 1 = phase high
  function automatic logic [2:0] f_vec(input logic [2:0] s);
    logic [2:0] v;
    case (s)
      3'd1:    v = 3'b001;
      3'd2:    v = 3'b011;
      3'd3:    v = 3'b010;
      3'd4:    v = 3'b110;
      3'd5:    v = 3'b100;
      3'd6:    v = 3'b101;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Target vector and fault detection from the registered command
  always_comb begin
    w_u_onehot   = (r_u_q == 3'b001) || (r_u_q == 3'b010) || (r_u_q == 3'b100);
    w_u_zero     = (r_u_q == 3'b001);
    w_sec_load   = w_u_zero || !r_en_q;
    w_sec_valid  = (SECTOR != 3'd0) && (SECTOR != 3'd7);
    w_fault_now  = r_en_q && (!w_u_onehot || (w_sec_load && !w_sec_valid));
    w_sector_nxt = (r_sector_q == 3'd6) ? 3'd1 : (r_sector_q + 3'd1);
    w_target     = 3'b000;
    if (r_u_q == 3'b010) begin
      w_target = f_vec(r_sector_q);
    end else if (r_u_q == 3'b100) begin
      w_target = f_vec(w_sector_nxt);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_u_q      <= 3'b001;
      r_en_q     <= 1'b0;
      r_sector_q <= 3'd1;
      r_gate_hi  <= 3'b000;
      r_gate_lo  <= 3'b000;
      r_fault    <= 1'b0;
      for (int i = 0; i < NPH; i++) begin
        r_state[i] <= PH_OFF;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_u_q  <= {U_HIGH, U_LOW, U_0};
      r_en_q <= ENABLE;
      // Sector only moves outside active vectors; illegal sectors never load
      if (w_sec_load && w_sec_valid) begin
        r_sector_q <= SECTOR;
      end

      if (!r_en_q) begin
        r_fault   <= 1'b0;
        r_gate_hi <= 3'b000;
        r_gate_lo <= 3'b000;
        for (int i = 0; i < NPH; i++) begin
          r_state[i] <= PH_OFF;
          r_cnt[i]   <= '0;
        end
      end else if (w_fault_now || r_fault) begin
        r_fault   <= 1'b1;
        r_gate_hi <= 3'b000;
        r_gate_lo <= 3'b000;
        for (int i = 0; i < NPH; i++) begin
          r_state[i] <= PH_OFF;
          r_cnt[i]   <= '0;
        end
      end else begin
        for (int i = 0; i < NPH; i++) begin
          case (r_state[i])
            PH_OFF: begin
              r_state[i]   <= PH_DEAD;
              r_cnt[i]     <= DT_W'(DEAD_CYCLES);
              r_gate_hi[i] <= 1'b0;
              r_gate_lo[i] <= 1'b0;
            end
            PH_DEAD: begin
              // Target may change during dead time; the count is never restarted
              if (r_cnt[i] == DT_W'(1)) begin
                r_state[i]   <= w_target[i] ? PH_ON_HI : PH_ON_LO;
                r_gate_hi[i] <= w_target[i];
                r_gate_lo[i] <= !w_target[i];
              end else begin
                r_cnt[i]     <= r_cnt[i] - DT_W'(1);
                r_gate_hi[i] <= 1'b0;
                r_gate_lo[i] <= 1'b0;
              end
            end
            PH_ON_HI: begin
              if (!w_target[i]) begin
                r_state[i]   <= PH_DEAD;
                r_cnt[i]     <= DT_W'(DEAD_CYCLES);
                r_gate_hi[i] <= 1'b0;
                r_gate_lo[i] <= 1'b0;
              end else begin
                r_gate_hi[i] <= 1'b1;
                r_gate_lo[i] <= 1'b0;
              end
            end
            PH_ON_LO: begin
              if (w_target[i]) begin
                r_state[i]   <= PH_DEAD;
                r_cnt[i]     <= DT_W'(DEAD_CYCLES);
                r_gate_hi[i] <= 1'b0;
                r_gate_lo[i] <= 1'b0;
              end else begin
                r_gate_hi[i] <= 1'b0;
                r_gate_lo[i] <= 1'b1;
              end
            end
            default: begin
              r_state[i]   <= PH_OFF;
              r_gate_hi[i] <= 1'b0;
              r_gate_lo[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign GATE_HI = r_gate_hi;
  assign GATE_LO = r_gate_lo;
  assign FAULT   = r_fault;

endmodule
